// File: rtl/i2c_pkg.sv
// Shared types for the I2C target: FSM states, general-call address and bus event bundle.
package i2c_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 4;

   localparam logic [6:0] GEN_CALL_ADDR = 7'h00;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      RX_DATA,
      RX_ACK,
      TX_DATA,
      TX_ACK,
      WAIT_STOP
   } state_t;

   typedef struct packed {
      logic start;
      logic stop;
      logic scl_rise;
      logic scl_fall;
   } bus_evt_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser with history flops; emits registered START/STOP/SCL edge events
// and an SDA sample aligned with those events.
module i2c_bus_sync
   import i2c_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     scl,
   input  logic     sda,
   output bus_evt_t evt,
   output logic     sda_in
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_h;
   logic                   sda_h;
   logic                   scl_s;
   logic                   sda_s;
   bus_evt_t               evt_c;

   assign scl_s = scl_sync[SYNC_STAGES-1];
   assign sda_s = sda_sync[SYNC_STAGES-1];

   // Edge and START/STOP detection against the history flops
   always_comb begin
      evt_c          = '0;
      evt_c.scl_rise = scl_s & ~scl_h;
      evt_c.scl_fall = ~scl_s & scl_h;
      evt_c.start    = scl_s & scl_h & sda_h & ~sda_s;
      evt_c.stop     = scl_s & scl_h & ~sda_h & sda_s;
   end

   // Chains reset high (idle bus) so reset release cannot fake an event
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_h    <= 1'b1;
         sda_h    <= 1'b1;
         evt      <= '0;
         sda_in   <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
         scl_h    <= scl_s;
         sda_h    <= sda_s;
         evt      <= evt_c;
         sda_in   <= sda_s;
      end
   end

endmodule

// File: rtl/i2c_target.sv
// Single-address I2C target: address match, write receive with ACK, read transmit.
// Optional macro I2C_GEN_CALL_EN: also ACK the general-call write address 8'h00.
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR    = 7'h50,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scl,
   inout  wire               sda,
   input  logic [BYTE_W-1:0] tx_data,
   input  logic              rx_ready,
   output logic [BYTE_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              tx_req,
   output logic              rw,
   output logic              busy,
   output logic              addressed,
   output logic              done
);

   bus_evt_t          evt;
   logic              sda_in;
   state_t            state,    state_n;
   logic [CNT_W-1:0]  bitcnt,   bitcnt_n;
   logic [BYTE_W-1:0] sr,       sr_n;
   logic [BYTE_W-1:0] tx_sr,    tx_sr_n;
   logic              sda_low,  sda_low_n;
   logic [BYTE_W-1:0] rx_data_n;
   logic              rx_valid_n, tx_req_n, rw_n, busy_n, addressed_n, done_n;
   logic [BYTE_W-1:0] shift_in;
   logic              gen_call;

   i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .rst    (rst),
      .scl    (scl),
      .sda    (sda),
      .evt    (evt),
      .sda_in (sda_in)
   );

   assign sda = sda_low ? 1'b0 : 1'bz;

   always_comb begin
      state_n     = state;
      bitcnt_n    = bitcnt;
      sr_n        = sr;
      tx_sr_n     = tx_sr;
      sda_low_n   = sda_low;
      rx_data_n   = rx_data;
      rx_valid_n  = 1'b0;
      tx_req_n    = 1'b0;
      done_n      = 1'b0;
      rw_n        = rw;
      busy_n      = busy;
      addressed_n = addressed;
      shift_in    = {sr[BYTE_W-2:0], sda_in};
`ifdef I2C_GEN_CALL_EN
      gen_call    = (shift_in == {GEN_CALL_ADDR, 1'b0});
`else
      gen_call    = 1'b0;
`endif

      if (evt.stop) begin
         state_n     = IDLE;
         sda_low_n   = 1'b0;
         busy_n      = 1'b0;
         done_n      = addressed;
         addressed_n = 1'b0;
      end else if (evt.start) begin
         state_n     = ADDR;
         bitcnt_n    = '0;
         sda_low_n   = 1'b0;
         busy_n      = 1'b1;
         addressed_n = 1'b0;
      end else begin
         unique case (state)
            ADDR: if (evt.scl_rise) begin
               sr_n     = shift_in;
               bitcnt_n = bitcnt + CNT_W'(1);
               if (bitcnt == CNT_W'(7)) begin
                  bitcnt_n = '0;
                  if (shift_in[7:1] == DEV_ADDR || gen_call) begin
                     addressed_n = 1'b1;
                     rw_n        = shift_in[0];
                     state_n     = ADDR_ACK;
                  end else begin
                     state_n = WAIT_STOP;
                  end
               end
            end
            // First fall starts the ACK; the fall after the ACK bit ends it
            ADDR_ACK: if (evt.scl_fall) begin
               if (!sda_low) begin
                  sda_low_n = 1'b1;
               end else if (rw) begin
                  tx_sr_n   = {tx_data[BYTE_W-2:0], 1'b1};
                  sda_low_n = ~tx_data[BYTE_W-1];
                  bitcnt_n  = CNT_W'(1);
                  state_n   = TX_DATA;
               end else begin
                  sda_low_n = 1'b0;
                  bitcnt_n  = '0;
                  state_n   = RX_DATA;
               end
            end else if (evt.scl_rise && rw && sda_low) begin
               tx_req_n = 1'b1;
            end
            RX_DATA: if (evt.scl_rise) begin
               sr_n     = shift_in;
               bitcnt_n = bitcnt + CNT_W'(1);
               if (bitcnt == CNT_W'(7)) begin
                  bitcnt_n = '0;
                  if (rx_ready) begin
                     rx_data_n  = shift_in;
                     rx_valid_n = 1'b1;
                     state_n    = RX_ACK;
                  end else begin
                     state_n = WAIT_STOP;
                  end
               end
            end
            RX_ACK: if (evt.scl_fall) begin
               if (!sda_low) begin
                  sda_low_n = 1'b1;
               end else begin
                  sda_low_n = 1'b0;
                  state_n   = RX_DATA;
               end
            end
            // bitcnt counts bits already driven; 0 means a fresh byte must be loaded
            TX_DATA: if (evt.scl_fall) begin
               if (bitcnt == '0) begin
                  tx_sr_n   = {tx_data[BYTE_W-2:0], 1'b1};
                  sda_low_n = ~tx_data[BYTE_W-1];
                  bitcnt_n  = CNT_W'(1);
               end else if (bitcnt == CNT_W'(8)) begin
                  sda_low_n = 1'b0;
                  state_n   = TX_ACK;
               end else begin
                  sda_low_n = ~tx_sr[BYTE_W-1];
                  tx_sr_n   = {tx_sr[BYTE_W-2:0], 1'b1};
                  bitcnt_n  = bitcnt + CNT_W'(1);
               end
            end
            TX_ACK: if (evt.scl_rise) begin
               if (!sda_in) begin
                  tx_req_n = 1'b1;
                  bitcnt_n = '0;
                  state_n  = TX_DATA;
               end else begin
                  state_n = WAIT_STOP;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bitcnt    <= '0;
         sr        <= '0;
         tx_sr     <= '0;
         sda_low   <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         tx_req    <= 1'b0;
         done      <= 1'b0;
         rw        <= 1'b0;
         busy      <= 1'b0;
         addressed <= 1'b0;
      end else begin
         state     <= state_n;
         bitcnt    <= bitcnt_n;
         sr        <= sr_n;
         tx_sr     <= tx_sr_n;
         sda_low   <= sda_low_n;
         rx_data   <= rx_data_n;
         rx_valid  <= rx_valid_n;
         tx_req    <= tx_req_n;
         done      <= done_n;
         rw        <= rw_n;
         busy      <= busy_n;
         addressed <= addressed_n;
      end
   end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: table of write transfers plus hand-written read,
// repeated-start and reset sequences, driven by a bit-banged bus master.
`timescale 1ns/1ps
module tb_i2c_target;

   localparam int Q = 8;
   localparam int H = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       scl;
   logic       m_sda_low;
   wire        sda;
   logic [7:0] tx_data;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, tx_req, rw, busy, addressed, done;

   int n_checks = 0;
   int n_fail   = 0;
   int rxv_cnt  = 0;
   int txr_cnt  = 0;
   int done_cnt = 0;

   pullup (sda);
   assign sda = m_sda_low ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   i2c_target dut (
      .clk       (clk),
      .rst       (rst),
      .scl       (scl),
      .sda       (sda),
      .tx_data   (tx_data),
      .rx_ready  (rx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .tx_req    (tx_req),
      .rw        (rw),
      .busy      (busy),
      .addressed (addressed),
      .done      (done)
   );

   // Pulse counters: a pulse wider than one cycle counts more than once
   always @(negedge clk) begin
      if (rx_valid) rxv_cnt  <= rxv_cnt + 1;
      if (tx_req)   txr_cnt  <= txr_cnt + 1;
      if (done)     done_cnt <= done_cnt + 1;
   end

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      logic       rdy;
      logic       ack_a;
      logic       ack_d;
      logic       adr;
      int         rxv;
      logic [7:0] rxd;
      int         dn;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_out(input logic b);
      m_sda_low = ~b;
      cyc(Q); scl = 1'b1;
      cyc(H); scl = 1'b0;
      cyc(Q);
   endtask

   task automatic bit_in(output logic b);
      m_sda_low = 1'b0;
      cyc(Q); scl = 1'b1;
      cyc(H/2); b = sda;
      cyc(H/2); scl = 1'b0;
      cyc(Q);
   endtask

   task automatic byte_out(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) bit_out(v[i]);
   endtask

   task automatic byte_in(output logic [7:0] v);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         bit_in(b);
         v[i] = b;
      end
   endtask

   task automatic m_start();
      m_sda_low = 1'b0;
      cyc(Q); scl = 1'b1;
      cyc(H); m_sda_low = 1'b1;
      cyc(H); scl = 1'b0;
      cyc(Q);
   endtask

   task automatic m_stop();
      m_sda_low = 1'b1;
      cyc(Q); scl = 1'b1;
      cyc(H); m_sda_low = 1'b0;
      cyc(H);
   endtask

   // Address + one data byte; ack bits are bus levels (0 = ACK); no STOP issued
   task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic rdy,
                     output logic ack_a, output logic ack_d);
      m_start();
      byte_out(a);
      bit_in(ack_a);
      ack_d = 1'b1;
      if (ack_a == 1'b0) begin
         rx_ready = rdy;
         byte_out(d);
         bit_in(ack_d);
      end
   endtask

   initial begin
      logic       ack_a, ack_d, b;
      logic [7:0] v;
      int         rxv0, txr0, dn0;

      vecs[0] = '{8'hA0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1, 8'hA5, 1};
      vecs[1] = '{8'hA2, 8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 0, 8'hA5, 0};
      vecs[2] = '{8'hA0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 0, 8'hA5, 1};
      vecs[3] = '{8'hA0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1, 8'h00, 1};
      vecs[4] = '{8'h01, 8'h42, 1'b1, 1'b1, 1'b1, 1'b0, 0, 8'h00, 0};
`ifdef I2C_GEN_CALL_EN
      vecs[5] = '{8'h00, 8'h42, 1'b1, 1'b0, 1'b0, 1'b1, 1, 8'h42, 1};
`else
      vecs[5] = '{8'h00, 8'h42, 1'b1, 1'b1, 1'b1, 1'b0, 0, 8'h00, 0};
`endif

      rst = 1'b1; scl = 1'b1; m_sda_low = 1'b0; tx_data = 8'h00; rx_ready = 1'b1;
      cyc(5);
      rst = 1'b0;
      cyc(5);
      check("reset rx_data", 32'(rx_data), 32'h0);
      check("reset flags", 32'({rx_valid, tx_req, rw, busy, addressed, done}), 32'h0);
      check("reset sda released", 32'(sda), 32'h1);

      foreach (vecs[i]) begin
         rxv0 = rxv_cnt; dn0 = done_cnt;
         wr(vecs[i].addr, vecs[i].data, vecs[i].rdy, ack_a, ack_d);
         check($sformatf("v%0d busy mid", i), 32'(busy), 32'h1);
         check($sformatf("v%0d addr ack", i), 32'(ack_a), 32'(vecs[i].ack_a));
         check($sformatf("v%0d data ack", i), 32'(ack_d), 32'(vecs[i].ack_d));
         check($sformatf("v%0d addressed", i), 32'(addressed), 32'(vecs[i].adr));
         m_stop();
         cyc(4);
         check($sformatf("v%0d rx_valid count", i), 32'(rxv_cnt - rxv0), 32'(vecs[i].rxv));
         check($sformatf("v%0d rx_data", i), 32'(rx_data), 32'(vecs[i].rxd));
         check($sformatf("v%0d done count", i), 32'(done_cnt - dn0), 32'(vecs[i].dn));
         check($sformatf("v%0d idle after stop", i), 32'({busy, addressed}), 32'h0);
      end

      // Single-byte read, master NACK
      tx_data = 8'h3C; txr0 = txr_cnt; dn0 = done_cnt;
      m_start();
      byte_out(8'hA1);
      bit_in(b);
      check("rd1 addr ack", 32'(b), 32'h0);
      check("rd1 rw", 32'(rw), 32'h1);
      check("rd1 tx_req count", 32'(txr_cnt - txr0), 32'h1);
      byte_in(v);
      check("rd1 byte", 32'(v), 32'h3C);
      bit_out(1'b1);
      bit_in(b);
      check("rd1 released after nack", 32'(b), 32'h1);
      m_stop();
      cyc(4);
      check("rd1 tx_req total", 32'(txr_cnt - txr0), 32'h1);
      check("rd1 done count", 32'(done_cnt - dn0), 32'h1);

      // Two-byte read, master ACK then NACK
      tx_data = 8'h12; txr0 = txr_cnt; dn0 = done_cnt;
      m_start();
      byte_out(8'hA1);
      bit_in(b);
      check("rd2 addr ack", 32'(b), 32'h0);
      byte_in(v);
      check("rd2 byte0", 32'(v), 32'h12);
      tx_data = 8'h34;
      bit_out(1'b0);
      check("rd2 tx_req after ack", 32'(txr_cnt - txr0), 32'h2);
      byte_in(v);
      check("rd2 byte1", 32'(v), 32'h34);
      bit_out(1'b1);
      m_stop();
      cyc(4);
      check("rd2 tx_req total", 32'(txr_cnt - txr0), 32'h2);
      check("rd2 done count", 32'(done_cnt - dn0), 32'h1);

      // rx_ready low NACKs the byte, then repeated START to a good write
      rxv0 = rxv_cnt; dn0 = done_cnt;
      wr(8'hA0, 8'h3C, 1'b0, ack_a, ack_d);
      check("rs nack data", 32'({ack_a, ack_d}), 32'h1);
      wr(8'hA0, 8'h77, 1'b1, ack_a, ack_d);
      check("rs acks", 32'({ack_a, ack_d}), 32'h0);
      m_stop();
      cyc(4);
      check("rs rx_data", 32'(rx_data), 32'h77);
      check("rs rx_valid count", 32'(rxv_cnt - rxv0), 32'h1);
      check("rs done count", 32'(done_cnt - dn0), 32'h1);

      // Reset mid address byte
      dn0 = done_cnt;
      m_start();
      for (int i = 0; i < 4; i++) bit_out(1'b1);
      check("rst1 busy before", 32'(busy), 32'h1);
      rst = 1'b1; cyc(1);
      check("rst1 outputs", 32'({rx_data, rx_valid, tx_req, rw, busy, addressed, done}), 32'h0);
      rst = 1'b0; m_sda_low = 1'b0; scl = 1'b1; cyc(H);

      // Reset while the target is driving the address ACK
      tx_data = 8'h00;
      m_start();
      byte_out(8'hA1);
      m_sda_low = 1'b0; cyc(2);
      check("rst2 ack driven", 32'(sda), 32'h0);
      check("rst2 addressed rw", 32'({addressed, rw}), 32'h3);
      rst = 1'b1; cyc(1);
      check("rst2 sda released", 32'(sda), 32'h1);
      check("rst2 outputs", 32'({rx_data, rx_valid, tx_req, rw, busy, addressed, done}), 32'h0);
      rst = 1'b0; scl = 1'b1; cyc(H);
      check("rst no done", 32'(done_cnt - dn0), 32'h0);

      // Full write after reset recovery
      rxv0 = rxv_cnt; dn0 = done_cnt;
      wr(8'hA0, 8'h5A, 1'b1, ack_a, ack_d);
      check("post-rst acks", 32'({ack_a, ack_d}), 32'h0);
      m_stop();
      cyc(4);
      check("post-rst rx_data", 32'(rx_data), 32'h5A);
      check("post-rst rx_valid", 32'(rxv_cnt - rxv0), 32'h1);
      check("post-rst done", 32'(done_cnt - dn0), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
